// File: rtl/ram_read_scanner.sv
// Walks the RAM read port through every word and latches addr/data for display.
// Optional manual step input when SCAN_STEP_EN is defined.
module ram_read_scanner #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 3,
  parameter int TICK_DIV = 50_000_000,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
`ifdef SCAN_STEP_EN
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              cap_pulse,
  output logic              wrap
);

  localparam int DIV_W =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(TICK_DIV - 1);
  localparam logic [1:0] LAT_LAST =
    2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_COUNT,
    S_LAT,
    S_CAPT
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        lat_q, lat_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_valid_q, disp_valid_d;
  logic              cap_pulse_q, cap_pulse_d;
  logic              wrap_q, wrap_d;

  logic step_req;
  logic div_term;
  logic advance;

`ifdef SCAN_STEP_EN
  assign step_req = step;
`else
  assign step_req = 1'b0;
`endif

  assign div_term = (div_q == DIV_LAST);
  assign advance  = (state_q == S_COUNT) &&
                    ((enable && div_term) || step_req);

  // Next-state: divider, address advance, latency wait, capture
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    lat_d        = lat_q;
    rd_addr_d    = rd_addr_q;
    disp_addr_d  = disp_addr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;
    cap_pulse_d  = 1'b0;
    wrap_d       = 1'b0;

    // Divider keeps running during the read wait; it parks at
    // terminal count so a frozen-then-resumed scan advances once.
    if (enable && !div_term) begin
      div_d = div_q + 1'b1;
    end

    unique case (state_q)
      S_COUNT: begin
        if (advance) begin
          rd_addr_d = rd_addr_q + 1'b1;
          wrap_d    = &rd_addr_q;
          div_d     = '0;
          lat_d     = '0;
          state_d   = S_LAT;
        end
      end
      S_LAT: begin
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          state_d = S_CAPT;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_CAPT: begin
        disp_addr_d  = rd_addr_q;
        disp_data_d  = rd_data;
        disp_valid_d = 1'b1;
        cap_pulse_d  = 1'b1;
        state_d      = S_COUNT;
      end
      default: begin
        state_d = S_LAT;
        lat_d   = '0;
      end
    endcase
  end

  // State registers; reset restarts the scan by re-reading word 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_LAT;
      div_q        <= '0;
      lat_q        <= '0;
      rd_addr_q    <= '0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      cap_pulse_q  <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      lat_q        <= lat_d;
      rd_addr_q    <= rd_addr_d;
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      cap_pulse_q  <= cap_pulse_d;
      wrap_q       <= wrap_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign disp_addr  = disp_addr_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign cap_pulse  = cap_pulse_q;
  assign wrap       = wrap_q;

endmodule
